// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: request/response bus shared by the requesters, the arbiter and memory.
// Requester side: req_vld/req_rdy/req_we/req_addr/req_wdata (flattened, requester i at slice i),
// rsp_vld one-hot strobe, rsp_data broadcast.
// Memory side: m_req_vld/m_req_rdy/m_req_we/m_req_addr/m_req_wdata, m_rsp_vld/m_rsp_data.
// Status: outstanding count, sticky err_unexpected_rsp.
// slave = arbiter view, master = requesters + memory view.
interface mem_req_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          m_req_vld;
    logic                          m_req_rdy;
    logic                          m_req_we;
    logic [ADDR_WIDTH-1:0]         m_req_addr;
    logic [DATA_WIDTH-1:0]         m_req_wdata;
    logic                          m_rsp_vld;
    logic [DATA_WIDTH-1:0]         m_rsp_data;
    logic [NUM_REQ-1:0]            rsp_vld;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [CW-1:0]                 outstanding;
    logic                          err_unexpected_rsp;
    modport slave (
        input  req_vld, req_we, req_addr, req_wdata, m_req_rdy, m_rsp_vld, m_rsp_data,
        output req_rdy, m_req_vld, m_req_we, m_req_addr, m_req_wdata, rsp_vld, rsp_data,
               outstanding, err_unexpected_rsp
    );
    modport master (
        output req_vld, req_we, req_addr, req_wdata, m_req_rdy, m_rsp_vld, m_rsp_data,
        input  req_rdy, m_req_vld, m_req_we, m_req_addr, m_req_wdata, rsp_vld, rsp_data,
               outstanding, err_unexpected_rsp
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter sharing one in-order memory port among NUM_REQ requesters.
// Ports: clk, rst_n (sync, active-low), bus (mem_req_arbiter_if.slave) carrying the requester
// handshakes, the memory request/response port and the outstanding/error status.
module mem_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_req_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_q, rr_d, lid_q, lid_d, grant;
    logic          lock_q, lock_d, gnt_vld, full, empty, issue, pop;
    logic [IW-1:0] tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // Descending scan so the lowest offset from rr_q is the last (winning) assignment.
    always_comb begin
        gnt_vld = lock_q;
        grant   = lid_q;
        if (!lock_q)
            for (int k = NUM_REQ - 1; k >= 0; k--)
                if (bus.req_vld[(int'(rr_q) + k) % NUM_REQ]) begin
                    gnt_vld = 1'b1;
                    grant   = IW'((int'(rr_q) + k) % NUM_REQ);
                end
    end

    assign full  = cnt_q == CW'(MAX_OUTSTANDING);
    assign empty = cnt_q == '0;
    assign issue = bus.m_req_vld && bus.m_req_rdy;
    assign pop   = bus.m_rsp_vld && !empty;

    assign bus.m_req_vld   = gnt_vld && !full;
    assign bus.m_req_we    = bus.req_we[grant];
    assign bus.m_req_addr  = bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.m_req_wdata = bus.req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.req_rdy     = issue ? NUM_REQ'(1) << grant : '0;
    assign bus.rsp_vld     = pop ? NUM_REQ'(1) << tag_q[rp_q] : '0;
    assign bus.rsp_data    = bus.m_rsp_data;
    assign bus.outstanding = cnt_q;
    assign bus.err_unexpected_rsp = err_q;

    // A stall freezes the grant; a handshake (or no request) releases it.
    always_comb begin
        rr_d   = issue ? IW'((int'(grant) + 1) % NUM_REQ) : rr_q;
        lock_d = bus.m_req_vld && !bus.m_req_rdy;
        lid_d  = grant;
        cnt_d  = cnt_q + CW'(issue) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lid_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            lid_q  <= lid_d;
            cnt_q  <= cnt_d;
            if (issue) begin
                tag_q[wp_q] <= grant;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop)
                rp_q <= rp_q + 1'b1;
            if (bus.m_rsp_vld && empty)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter.
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTSTANDING(4)) bus ();

    mem_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTSTANDING(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_vld    = '0;
        bus.req_we     = 4'b1010;
        bus.req_addr   = 32'h40302010;
        bus.req_wdata  = 32'hD4C3B2A1;
        bus.m_req_rdy  = 1'b0;
        bus.m_rsp_vld  = 1'b0;
        bus.m_rsp_data = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_req_rdy", 32'(bus.req_rdy), 0);
        check("rst_rsp_vld", 32'(bus.rsp_vld), 0);
        check("rst_m_req_vld", 32'(bus.m_req_vld), 0);
        check("rst_outstanding", 32'(bus.outstanding), 0);
        check("rst_err", 32'(bus.err_unexpected_rsp), 0);

        // Round-robin streaming, memory answers one cycle after each issue.
        bus.req_vld   = 4'b1111;
        bus.m_req_rdy = 1'b1;
        #1;
        check("rr0_req_rdy", 32'(bus.req_rdy), 32'h1);
        check("rr0_addr", 32'(bus.m_req_addr), 32'h10);
        check("rr0_we", 32'(bus.m_req_we), 0);
        step();
        bus.m_rsp_vld  = 1'b1;
        bus.m_rsp_data = 8'h55;
        #1;
        check("rr1_addr", 32'(bus.m_req_addr), 32'h20);
        check("rr1_we", 32'(bus.m_req_we), 1);
        check("rr1_wdata", 32'(bus.m_req_wdata), 32'hB2);
        check("rr1_rsp_data", 32'(bus.rsp_data), 32'h55);
        for (int c = 1; c <= 7; c++) begin
            check("rr_req_rdy", 32'(bus.req_rdy), 32'(1) << (c % 4));
            check("rr_rsp_vld", 32'(bus.rsp_vld), 32'(1) << ((c - 1) % 4));
            check("rr_outstanding", 32'(bus.outstanding), 1);
            step();
        end
        bus.req_vld = '0;
        #1;
        check("rr_last_rsp", 32'(bus.rsp_vld), 32'h8);
        check("rr_last_m_vld", 32'(bus.m_req_vld), 0);
        step();
        bus.m_rsp_vld = 1'b0;
        #1;
        check("rr_drained", 32'(bus.outstanding), 0);

        // Stall holds requester 0, then requester 2 follows.
        bus.req_vld   = 4'b0101;
        bus.m_req_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_m_vld", 32'(bus.m_req_vld), 1);
            check("stall_addr", 32'(bus.m_req_addr), 32'h10);
            check("stall_req_rdy", 32'(bus.req_rdy), 0);
            step();
        end
        bus.m_req_rdy = 1'b1;
        #1;
        check("stall_rel_addr", 32'(bus.m_req_addr), 32'h10);
        check("stall_rel_rdy", 32'(bus.req_rdy), 32'h1);
        step();
        check("next_grant_rdy", 32'(bus.req_rdy), 32'h4);
        check("next_grant_addr", 32'(bus.m_req_addr), 32'h30);
        step();
        bus.req_vld   = '0;
        bus.m_req_rdy = 1'b0;
        #1;
        check("two_out", 32'(bus.outstanding), 2);

        // Issue and response together at outstanding=2 (FIFO holds 0,2; rr at 3).
        bus.req_vld   = 4'b1111;
        bus.m_req_rdy = 1'b1;
        bus.m_rsp_vld = 1'b1;
        #1;
        check("sim_req_rdy", 32'(bus.req_rdy), 32'h8);
        check("sim_rsp_vld", 32'(bus.rsp_vld), 32'h1);
        step();
        bus.m_rsp_vld = 1'b0;
        #1;
        check("sim_outstanding", 32'(bus.outstanding), 2);

        // Fill to MAX_OUTSTANDING (FIFO 2,3 -> 2,3,0,1).
        check("fill_rdy0", 32'(bus.req_rdy), 32'h1);
        step();
        check("fill_rdy1", 32'(bus.req_rdy), 32'h2);
        check("fill_out3", 32'(bus.outstanding), 3);
        step();
        check("full_out", 32'(bus.outstanding), 4);
        check("full_m_vld", 32'(bus.m_req_vld), 0);
        check("full_req_rdy", 32'(bus.req_rdy), 0);
        step();
        check("full_hold", 32'(bus.outstanding), 4);
        bus.m_rsp_vld = 1'b1;
        #1;
        check("full_pop_m_vld", 32'(bus.m_req_vld), 0);
        check("full_pop_rsp", 32'(bus.rsp_vld), 32'h4);
        step();
        bus.m_rsp_vld = 1'b0;
        #1;
        check("after_pop_out", 32'(bus.outstanding), 3);
        check("resume_m_vld", 32'(bus.m_req_vld), 1);
        check("resume_rdy", 32'(bus.req_rdy), 32'h4);
        step();
        bus.m_rsp_vld = 1'b1;
        #1;
        check("refull_out", 32'(bus.outstanding), 4);
        check("refull_rsp", 32'(bus.rsp_vld), 32'h8);
        step();
        bus.m_rsp_vld = 1'b0;
        bus.m_req_rdy = 1'b0;
        #1;
        check("pre_rst_out", 32'(bus.outstanding), 3);

        // Reset mid-operation, with a handshake offered while reset is sampled.
        rst_n         = 1'b0;
        bus.m_req_rdy = 1'b1;
        step();
        rst_n         = 1'b1;
        bus.m_req_rdy = 1'b0;
        #1;
        check("mrst_out", 32'(bus.outstanding), 0);
        check("mrst_err", 32'(bus.err_unexpected_rsp), 0);
        check("mrst_grant", 32'(bus.m_req_addr), 32'h10);
        check("mrst_m_vld", 32'(bus.m_req_vld), 1);

        // Unexpected response sets the sticky error.
        bus.req_vld    = '0;
        bus.m_rsp_vld  = 1'b1;
        bus.m_rsp_data = 8'hA5;
        #1;
        check("unexp_rsp_vld", 32'(bus.rsp_vld), 0);
        check("unexp_data", 32'(bus.rsp_data), 32'hA5);
        step();
        bus.m_rsp_vld = 1'b0;
        #1;
        check("err_set", 32'(bus.err_unexpected_rsp), 1);
        check("err_out", 32'(bus.outstanding), 0);
        step();
        step();
        check("err_sticky", 32'(bus.err_unexpected_rsp), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("err_cleared", 32'(bus.err_unexpected_rsp), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
